// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus signals between the core ports and mem_ctrl.
// slave = controller view, master = core + RAM view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              IF_MC_ask;
  logic [ADDR_W-1:0] IF_MC_Addr;
  logic              MC_IF_ok;
  logic              MC_IF_arrive;
  logic [31:0]       MC_IF_Inst;

  logic              LSB_MC_ask;
  logic              LSB_MC_wr;
  logic [1:0]        LSB_MC_Len;
  logic [ADDR_W-1:0] LSB_MC_Addr;
  logic [31:0]       LSB_MC_Data;
  logic              MC_LSB_ok;
  logic              MC_LSB_arrive;
  logic [31:0]       MC_LSB_Data;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  // Handshake: an ask is held high until the matching ok pulse; ok and
  // arrive are single-cycle registered pulses, with arrive never before ok.
  modport slave (
    input  IF_MC_ask, IF_MC_Addr,
    input  LSB_MC_ask, LSB_MC_wr, LSB_MC_Len, LSB_MC_Addr, LSB_MC_Data,
    input  mem_din,
    output MC_IF_ok, MC_IF_arrive, MC_IF_Inst,
    output MC_LSB_ok, MC_LSB_arrive, MC_LSB_Data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output IF_MC_ask, IF_MC_Addr,
    output LSB_MC_ask, LSB_MC_wr, LSB_MC_Len, LSB_MC_Addr, LSB_MC_Data,
    output mem_din,
    input  MC_IF_ok, MC_IF_arrive, MC_IF_Inst,
    input  MC_LSB_ok, MC_LSB_arrive, MC_LSB_Data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: one fetch or load/store in flight, LS port
// has priority. All outputs registered; state exposed on dbg_state_o.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       io_buffer_full,
  input  logic       clr_in,
  mem_ctrl_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, LS_RD = 2'd2, LS_WR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        hold_q, hold_d;
  logic              paused_q, paused_d;
  logic              if_ok_q, if_ok_d, if_arr_q, if_arr_d;
  logic              ls_ok_q, ls_ok_d, ls_arr_q, ls_arr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [ADDR_W-1:0] wr_addr, rd_next;
  logic [7:0]        rd_byte;
  logic              wr_stall, acc_stall;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  assign wr_addr   = addr_q + ADDR_W'(cnt_q);
  assign rd_next   = wr_addr + ADDR_W'(1);
  assign wr_stall  = io_buffer_full && (wr_addr[17:16] == IO_SEL);
  assign acc_stall = io_buffer_full && (bus.LSB_MC_Addr[17:16] == IO_SEL);
  // The byte RAM returned on the first paused edge would be lost while
  // mem_a is frozen, so it is kept and consumed on the resume edge.
  assign rd_byte   = paused_q ? hold_q : bus.mem_din;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hold_d     = hold_q;
    paused_d   = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_ok_d    = 1'b0;
    if_arr_d   = 1'b0;
    ls_ok_d    = 1'b0;
    ls_arr_d   = 1'b0;
    if (!rdy_in) begin
      paused_d = 1'b1;
      if (!paused_q) hold_d = bus.mem_din;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.LSB_MC_ask) begin
            ls_ok_d  = 1'b1;
            addr_d   = bus.LSB_MC_Addr;
            wdata_d  = bus.LSB_MC_Data;
            nbytes_d = {1'b0, bus.LSB_MC_Len} + 3'd1;
            mem_a_d  = bus.LSB_MC_Addr;
            rdata_d  = '0;
            cnt_d    = 3'd0;
            if (bus.LSB_MC_wr) begin
              state_d    = LS_WR;
              mem_dout_d = bus.LSB_MC_Data[7:0];
              if (!acc_stall) begin
                mem_wr_d = 1'b1;
                cnt_d    = 3'd1;
              end
            end else begin
              state_d = LS_RD;
            end
          end else if (bus.IF_MC_ask && !clr_in) begin
            if_ok_d  = 1'b1;
            addr_d   = bus.IF_MC_Addr;
            nbytes_d = 3'd4;
            mem_a_d  = bus.IF_MC_Addr;
            rdata_d  = '0;
            cnt_d    = 3'd0;
            state_d  = IF_RD;
          end
        end
        IF_RD, LS_RD: begin
          if (state_q == IF_RD && clr_in) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d < nbytes_q) mem_a_d = rd_next;
            // cnt_q = k captures byte k-1 (RAM answers one cycle late).
            case (cnt_q)
              3'd1:    rdata_d[7:0]   = rd_byte;
              3'd2:    rdata_d[15:8]  = rd_byte;
              3'd3:    rdata_d[23:16] = rd_byte;
              3'd4:    rdata_d[31:24] = rd_byte;
              default: ;
            endcase
            if (cnt_q == nbytes_q) begin
              state_d = IDLE;
              if (state_q == IF_RD) if_arr_d = 1'b1;
              else                  ls_arr_d = 1'b1;
            end
          end
        end
        LS_WR: begin
          if (cnt_q < nbytes_q) begin
            if (!wr_stall) begin
              mem_wr_d   = 1'b1;
              mem_a_d    = wr_addr;
              mem_dout_d = byte_of(wdata_q, cnt_q[1:0]);
              cnt_d      = cnt_q + 3'd1;
            end
          end else if (cnt_q == nbytes_q) begin
            ls_arr_d = 1'b1;
            cnt_d    = cnt_q + 3'd1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hold_q     <= '0;
      paused_q   <= 1'b0;
      if_ok_q    <= 1'b0;
      if_arr_q   <= 1'b0;
      ls_ok_q    <= 1'b0;
      ls_arr_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hold_q     <= hold_d;
      paused_q   <= paused_d;
      if_ok_q    <= if_ok_d;
      if_arr_q   <= if_arr_d;
      ls_ok_q    <= ls_ok_d;
      ls_arr_q   <= ls_arr_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.MC_IF_ok      = if_ok_q;
  assign bus.MC_IF_arrive  = if_arr_q;
  assign bus.MC_IF_Inst    = rdata_q;
  assign bus.MC_LSB_ok     = ls_ok_q;
  assign bus.MC_LSB_arrive = ls_arr_q;
  assign bus.MC_LSB_Data   = rdata_q;
  assign bus.mem_a         = mem_a_q;
  assign bus.mem_dout      = mem_dout_q;
  assign bus.mem_wr        = mem_wr_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, priority, store, IO stall, pause,
// flush and reset, against a 1-cycle-latency byte RAM model.
module tb_mem_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IF_RD = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       io_full;
  logic       clr;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  ram [int unsigned];
  logic [39:0] exp_q [$];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy),
    .io_buffer_full (io_full),
    .clr_in         (clr),
    .bus            (bus),
    .dbg_state_o    (dbg_state)
  );

  always #5 clk = ~clk;

  // RAM: byte addressed in one cycle appears on mem_din the next.
  always @(posedge clk)
    bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts negedges until the selected arrive is seen; max+1 on timeout.
  task automatic wait_arrive(input bit is_if, input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(is_if ? bus.MC_IF_arrive : bus.MC_LSB_arrive) && cyc <= max);
  endtask

  task automatic ls_req(input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    bus.LSB_MC_ask  = 1'b1;
    bus.LSB_MC_wr   = wr;
    bus.LSB_MC_Len  = len;
    bus.LSB_MC_Addr = a;
    bus.LSB_MC_Data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit any_arr;
    logic [39:0] e;

    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h0040] = 8'hA1; ram[32'h0041] = 8'hB2; ram[32'h0042] = 8'hC3; ram[32'h0043] = 8'hD4;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;

    rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0; clr = 1'b0;
    bus.IF_MC_ask = 1'b0; bus.IF_MC_Addr = '0;
    ls_req(1'b0, 2'd0, 32'h0, 32'h0);
    bus.LSB_MC_ask = 1'b0;
    tick(); tick();
    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_eq("rst_outs", {bus.MC_IF_ok, bus.MC_IF_arrive, bus.MC_LSB_ok, bus.MC_LSB_arrive, bus.mem_wr}, 0);
    check_eq("rst_mem_a", bus.mem_a, 0);
    check_eq("rst_inst", bus.MC_IF_Inst, 0);
    rst_n = 1'b1;
    tick();

    // T1: plain fetch
    bus.IF_MC_ask = 1'b1; bus.IF_MC_Addr = 32'h1000;
    tick();
    check_eq("t1_ok", bus.MC_IF_ok, 1);
    check_eq("t1_mem_a", bus.mem_a, 32'h1000);
    bus.IF_MC_ask = 1'b0;
    wait_arrive(1'b1, 10, cyc);
    check_eq("t1_lat", cyc, 5);
    check_eq("t1_inst", bus.MC_IF_Inst, 32'h0000_0513);
    check_eq("t1_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    tick();
    check_eq("t1_pulse", bus.MC_IF_arrive, 0);

    // T2: simultaneous asks, LSB load wins
    bus.IF_MC_ask = 1'b1; bus.IF_MC_Addr = 32'h1000;
    ls_req(1'b0, 2'd3, 32'h40, 32'h0);
    tick();
    check_eq("t2_ls_ok", bus.MC_LSB_ok, 1);
    check_eq("t2_if_no_ok", bus.MC_IF_ok, 0);
    bus.LSB_MC_ask = 1'b0;
    wait_arrive(1'b0, 10, cyc);
    check_eq("t2_ls_lat", cyc, 5);
    check_eq("t2_ls_data", bus.MC_LSB_Data, 32'hD4C3_B2A1);
    tick();
    check_eq("t2_if_ok", bus.MC_IF_ok, 1);
    bus.IF_MC_ask = 1'b0;
    wait_arrive(1'b1, 10, cyc);
    check_eq("t2_if_lat", cyc, 5);
    check_eq("t2_inst", bus.MC_IF_Inst, 32'h0000_0513);
    tick();

    // T3: 4-byte store, byte stream checked against the expected queue
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDEAD_BEEF;
      exp_q.push_back({32'h20 + 32'(i), w[8*i +: 8]});
    end
    ls_req(1'b1, 2'd3, 32'h20, 32'hDEAD_BEEF);
    tick();
    check_eq("t3_ok", bus.MC_LSB_ok, 1);
    bus.LSB_MC_ask = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      check_eq($sformatf("t3_wr%0d", k), bus.mem_wr, 1);
      check_eq($sformatf("t3_a%0d", k), bus.mem_a, e[39:8]);
      check_eq($sformatf("t3_d%0d", k), bus.mem_dout, e[7:0]);
      check_eq($sformatf("t3_noarr%0d", k), bus.MC_LSB_arrive, 0);
    end
    tick();
    check_eq("t3_arrive", bus.MC_LSB_arrive, 1);
    check_eq("t3_wr_off", bus.mem_wr, 0);
    tick();
    check_eq("t3_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_eq("t3_pulse", bus.MC_LSB_arrive, 0);

    // T4: IO store held off by a full buffer for 3 edges
    io_full = 1'b1;
    ls_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
    tick();
    check_eq("t4_ok", bus.MC_LSB_ok, 1);
    bus.LSB_MC_ask = 1'b0;
    check_eq("t4_stall0", bus.mem_wr, 0);
    tick();
    check_eq("t4_stall1", bus.mem_wr, 0);
    tick();
    check_eq("t4_stall2", bus.mem_wr, 0);
    io_full = 1'b0;
    tick();
    check_eq("t4_wr", bus.mem_wr, 1);
    check_eq("t4_a", bus.mem_a, 32'h0003_0000);
    check_eq("t4_d", bus.mem_dout, 32'h5A);
    tick();
    check_eq("t4_arrive", bus.MC_LSB_arrive, 1);
    check_eq("t4_once", bus.mem_wr, 0);
    tick();

    // T5: 2-cycle pause during a fetch
    bus.IF_MC_ask = 1'b1; bus.IF_MC_Addr = 32'h2000;
    tick();
    check_eq("t5_ok", bus.MC_IF_ok, 1);
    bus.IF_MC_ask = 1'b0;
    tick();
    rdy = 1'b0;
    tick();
    check_eq("t5_hold_a0", bus.mem_a, 32'h2001);
    tick();
    check_eq("t5_hold_a1", bus.mem_a, 32'h2001);
    check_eq("t5_noarr", bus.MC_IF_arrive, 0);
    rdy = 1'b1;
    wait_arrive(1'b1, 10, cyc);
    check_eq("t5_lat", cyc + 3, 7);
    check_eq("t5_inst", bus.MC_IF_Inst, 32'h4433_2211);
    tick();

    // T6a: flush mid fetch, then flush blocks a fresh IF accept
    bus.IF_MC_ask = 1'b1; bus.IF_MC_Addr = 32'h1000;
    tick();
    check_eq("t6_ok", bus.MC_IF_ok, 1);
    bus.IF_MC_ask = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    check_eq("t6_clr_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_eq("t6_clr_noarr", bus.MC_IF_arrive, 0);
    bus.IF_MC_ask = 1'b1;
    tick();
    check_eq("t6_clr_noacc", bus.MC_IF_ok, 0);
    check_eq("t6_clr_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    clr = 1'b0;
    tick();
    check_eq("t6_reacc", bus.MC_IF_ok, 1);
    check_eq("t6_rd_state", {30'd0, dbg_state}, {30'd0, ST_IF_RD});
    bus.IF_MC_ask = 1'b0;
    wait_arrive(1'b1, 10, cyc);
    check_eq("t6_lat", cyc, 5);
    check_eq("t6_inst", bus.MC_IF_Inst, 32'h0000_0513);
    tick();

    // T6b: reset in the middle of a store
    ls_req(1'b1, 2'd3, 32'h20, 32'h1234_5678);
    tick();
    bus.LSB_MC_ask = 1'b0;
    check_eq("t6_st_wr", bus.mem_wr, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_wr", bus.mem_wr, 0);
    check_eq("t6_rst_outs", {bus.MC_IF_ok, bus.MC_IF_arrive, bus.MC_LSB_ok, bus.MC_LSB_arrive}, 0);
    check_eq("t6_rst_a", bus.mem_a, 0);
    check_eq("t6_rst_dout", bus.mem_dout, 0);
    check_eq("t6_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    tick();
    rst_n = 1'b1;
    any_arr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.MC_LSB_arrive || bus.mem_wr) any_arr = 1'b1;
    end
    check_eq("t6_dropped", any_arr, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
